pi2bpsk_bit_feeder: RTL and testbench
=====================================

# pi2bpsk_bit_feeder

Upstream feeder for the pi/2-BPSK phase-index mapper in the PUCCH modulation chain. It accepts scrambled codeword bits as WORD_W-bit words over a valid/ready handshake and serialises them LSB-first. It emits one bit per symbol together with that symbol's running index, so the mapper receives its bit and index-LSB inputs directly from this block. The block covers one codeword per start pulse and discards any bits left over in the final word.

## Interface
Parameters:
- WORD_W, 8: input word width in bits; power of two, 2..32.
- IDX_W, 12: symbol index and bit count width; covers up to 4095 symbols.

Ports:
- i_clk  input  1  single clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  one-cycle pulse that begins a codeword.
- i_num_bits  input  IDX_W  codeword length in bits (= symbols); sampled on i_start.
- i_word  input  WORD_W  packed scrambled bits; bit 0 is transmitted first.
- i_word_valid  input  1  i_word is valid.
- o_word_ready  output  1  feeder accepts i_word this cycle.
- o_valid  output  1  o_b / o_index / o_index_lsb / o_last are valid.
- i_ready  input  1  downstream accepts the current bit.
- o_b  output  1  current bit.
- o_index  output  IDX_W  symbol index of the current bit, 0..N-1.
- o_index_lsb  output  1  o_index[0].
- o_last  output  1  current bit is bit N-1.
- o_busy  output  1  a codeword is in progress.
- o_err  output  1  one-cycle pulse when i_start is rejected.

## Operation
- States: IDLE, RUN.
- **IDLE:**
  - On i_start with i_num_bits != 0: latch N, clear the index, clear the word buffer, go to RUN.
  - On i_start with i_num_bits == 0: stay in IDLE and pulse o_err.
- **RUN:**
  - The word buffer holds one word plus a bit pointer (log2(WORD_W) bits).
  - o_valid = buffer non-empty.
  - o_b = buf[ptr].
  - o_word_ready = buffer empty, OR (ptr == WORD_W-1 AND o_valid AND i_ready AND NOT o_last).
- **Bit handshake** (o_valid && i_ready):
  - ptr increments and o_index increments.
  - When ptr wraps to 0, the buffer becomes empty unless a new word is accepted in the same cycle. In that case the buffer is reloaded and stays full.
- **Last bit** (o_last && handshake):
  - Go to IDLE, drop remaining buffered bits, deassert o_busy on the next cycle.
  - o_word_ready stays 0 so the next word is not consumed.
- **Rejected starts:**
  - i_start while in RUN is ignored and pulses o_err; the current codeword is unaffected.
  - i_start in the same cycle as the last-bit handshake also counts as busy: reject and pulse o_err.
- **Stalls:**
  - i_ready low holds all outputs stable.
  - An empty buffer with i_word_valid low deasserts o_valid (underflow stall); o_index holds its value.
- **Widths:** o_index wraps nowhere, because N is at most 2^IDX_W - 1 and the index stops at N-1.
- **Reset:** in any state, reset returns the block to IDLE immediately.

## Timing
- **Reset values:** o_word_ready 0, o_valid 0, o_b 0, o_index 0, o_index_lsb 0, o_last 0, o_busy 0, o_err 0; buffer is empty.
- **Start to busy:** i_start at edge k sets o_busy from k+1.
  - o_word_ready may be high from k+1, combinationally, while the buffer is empty.
- **Word to bit:** a word accepted at edge m makes o_valid high from m+1 with o_b = i_word[0].
- **Throughput:** with i_word_valid and i_ready held high, one bit is delivered per cycle with no gap at word boundaries.
- **Ready path:** o_word_ready depends combinationally on i_ready in the reload case. All other outputs are registered or depend only on the buffer.
- **o_err:** asserted exactly one cycle, on the edge after the rejected i_start.

## Structure
- Shared package pucch_pkg:
  - feeder state enum {IDLE, RUN}.
  - default IDX_W constant, shared with the downstream index/phase logic.
- No sub-module; the word buffer, pointer and index counter stay inline.

## Test plan
- **Single word:** reset, start with N=8, word 0xA5, i_ready=1.
  - Bits 1,0,1,0,0,1,0,1 on indices 0..7.
  - o_index_lsb alternates 0,1,…
  - o_last only at index 7; o_busy low after.
- **Multi-word, continuous:** N=20, words 0xFF, 0x00, 0x0F always valid, i_ready=1.
  - 20 consecutive valid cycles with no bubble.
  - Bits 16..19 = 1.
  - Only 3 words consumed; the upper nibble of 0x0F is dropped.
- **Backpressure and underflow:** N=16; i_ready low 3 cycles mid-word; then i_word_valid low 2 cycles at the word boundary.
  - Outputs hold during the i_ready stall.
  - o_valid drops for the underflow; indices stay contiguous 0..15.
- **Rejected starts:**
  - Start with N=0 → o_err 1 cycle, o_busy stays 0.
  - Start while RUN → o_err pulse; sequence unchanged.
  - Start coincident with the last handshake → o_err pulse, returns to IDLE.
- **Reset mid-codeword:** assert i_rst at index 5 of N=24.
  - All outputs 0 immediately.
  - A fresh start with N=8 restarts at index 0 from a new word.

Source files
------------

// File: rtl/pucch_pkg.sv
// Shared definitions for the PUCCH modulation chain: feeder state encoding
// and the default symbol-index width used by the feeder and the phase logic.
package pucch_pkg;

    typedef enum logic {
        FEED_IDLE = 1'b0,
        FEED_RUN  = 1'b1
    } feed_state_e;

    localparam int IDX_W_DEF = 12;

endpackage

// File: rtl/pi2bpsk_bit_feeder.sv
// Serialises scrambled codeword words LSB-first into one bit per symbol,
// tagging each bit with its running symbol index for the pi/2-BPSK mapper.
module pi2bpsk_bit_feeder
    import pucch_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [IDX_W-1:0]  i_num_bits,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_word_valid,
    output logic              o_word_ready,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_b,
    output logic [IDX_W-1:0]  o_index,
    output logic              o_index_lsb,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_err
);

    localparam int                 PTR_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(WORD_W - 1);

    feed_state_e        state_r;
    logic [IDX_W-1:0]   n_r;
    logic [IDX_W-1:0]   idx_r;
    logic [WORD_W-1:0]  buf_r;
    logic [PTR_W-1:0]   ptr_r;
    logic               full_r;
    logic               err_r;

    logic               last_s;
    logic               word_ready_s;
    logic               handshake_s;
    logic               word_take_s;

    // Last-bit detect and word-ready; reload is allowed only as the final bit of a word drains
    always_comb begin
        last_s       = 1'b0;
        word_ready_s = 1'b0;
        if (state_r == FEED_RUN) begin
            last_s       = full_r && (idx_r == (n_r - IDX_W'(1)));
            word_ready_s = !full_r || (full_r && (ptr_r == PTR_LAST) && i_ready && !last_s);
        end else begin
            last_s       = 1'b0;
            word_ready_s = 1'b0;
        end
    end

    assign handshake_s = full_r && i_ready;
    assign word_take_s = word_ready_s && i_word_valid;

    // Feeder FSM with word buffer, bit pointer and symbol index counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= FEED_IDLE;
            n_r     <= {IDX_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            buf_r   <= {WORD_W{1'b0}};
            ptr_r   <= {PTR_W{1'b0}};
            full_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                FEED_IDLE: begin
                    if (i_start) begin
                        if (i_num_bits != {IDX_W{1'b0}}) begin
                            n_r     <= i_num_bits;
                            idx_r   <= {IDX_W{1'b0}};
                            buf_r   <= {WORD_W{1'b0}};
                            ptr_r   <= {PTR_W{1'b0}};
                            full_r  <= 1'b0;
                            state_r <= FEED_RUN;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end else begin
                        state_r <= FEED_IDLE;
                    end
                end
                FEED_RUN: begin
                    // A start while a codeword is in flight (even on its last bit) is refused
                    if (i_start) begin
                        err_r <= 1'b1;
                    end else begin
                        err_r <= 1'b0;
                    end
                    if (handshake_s && last_s) begin
                        state_r <= FEED_IDLE;
                        full_r  <= 1'b0;
                        buf_r   <= {WORD_W{1'b0}};
                        ptr_r   <= {PTR_W{1'b0}};
                    end else begin
                        if (handshake_s) begin
                            ptr_r <= ptr_r + PTR_W'(1);
                            idx_r <= idx_r + IDX_W'(1);
                        end else begin
                            ptr_r <= ptr_r;
                        end
                        if (word_take_s) begin
                            buf_r  <= i_word;
                            full_r <= 1'b1;
                            ptr_r  <= {PTR_W{1'b0}};
                        end else if (handshake_s && (ptr_r == PTR_LAST)) begin
                            full_r <= 1'b0;
                        end else begin
                            full_r <= full_r;
                        end
                    end
                end
                default: begin
                    state_r <= FEED_IDLE;
                    full_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_word_ready = word_ready_s;
    assign o_valid      = full_r;
    assign o_b          = full_r & buf_r[ptr_r];
    assign o_index      = idx_r;
    assign o_index_lsb  = idx_r[0];
    assign o_last       = last_s;
    assign o_busy       = (state_r == FEED_RUN);
    assign o_err        = err_r;

endmodule

// File: tb/tb_pi2bpsk_bit_feeder.sv
// Randomised bench for pi2bpsk_bit_feeder: a bit-stream model built from the
// supplied words predicts every output bit, index, ready and error pulse.
module tb_pi2bpsk_bit_feeder;

    localparam int W  = 8;
    localparam int IW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [IW-1:0] num;
    logic [W-1:0]  word;
    logic          wv;
    logic          wr;
    logic          ov;
    logic          rdy;
    logic          ob;
    logic [IW-1:0] oidx;
    logic          olsb;
    logic          olast;
    logic          busy;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] wq[$];

    pi2bpsk_bit_feeder #(.WORD_W(W), .IDX_W(IW)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_bits(num),
        .i_word(word), .i_word_valid(wv), .o_word_ready(wr), .o_valid(ov),
        .i_ready(rdy), .o_b(ob), .o_index(oidx), .o_index_lsb(olsb),
        .o_last(olast), .o_busy(busy), .o_err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_random(input int n);
        wq.delete();
        for (int i = 0; i < (n + W - 1) / W; i++) wq.push_back(W'($urandom));
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_valid"}, ov, 0);
        check_eq({tag, "_wready"}, wr, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_b"}, ob, 0);
        check_eq({tag, "_index"}, oidx, 0);
        check_eq({tag, "_lsb"}, olsb, 0);
        check_eq({tag, "_last"}, olast, 0);
        check_eq({tag, "_err"}, err, 0);
    endtask

    // Runs one codeword of n bits from wq; expected stream is wq bits LSB-first.
    task automatic run_cw(input int n, input int p_rdy, input int p_wv,
                          input int inj_mid, input bit inj_last, input int abort_at);
        int k = 0, taken = 0, cyc = 0, bubbles = 0, avail;
        bit seen = 0, err_exp = 0, injected = 0, hs, wacc, exp_ready;
        @(negedge clk);
        start = 1'b1; num = IW'(n); wv = 1'b0; rdy = 1'b0;
        @(posedge clk);
        while (k < n && cyc < 40 * n + 200) begin
            @(negedge clk);
            cyc++;
            check_eq("err_pulse", err, err_exp);
            err_exp = 0;
            check_eq("busy_run", busy, 1);
            start = 1'b0;
            rdy  = ($urandom_range(99) < p_rdy);
            wv   = (taken < wq.size()) && ($urandom_range(99) < p_wv);
            word = wv ? wq[taken] : W'($urandom);
            if (!injected && k == inj_mid) begin
                injected = 1; start = 1'b1; num = IW'($urandom_range(4095));
            end
            if (inj_last && k == n - 1) begin
                rdy = 1'b1; start = 1'b1; num = IW'(5);
            end
            if (abort_at >= 0 && k == abort_at) begin
                rst = 1'b1; start = 1'b0; wv = 1'b0;
                #1;
                check_idle("abort");
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            #1;
            avail     = taken * W - k;
            exp_ready = (avail == 0) || (avail == 1 && rdy && k != n - 1);
            check_eq("word_ready", wr, exp_ready);
            check_eq("valid", ov, avail > 0);
            check_eq("index", oidx, k);
            if (avail > 0) begin
                check_eq("bit", ob, wq[k / W][k % W]);
                check_eq("index_lsb", olsb, k % 2);
                check_eq("last", olast, k == n - 1);
            end
            if (seen && avail == 0) bubbles++;
            hs   = ov && rdy;
            wacc = wr && wv;
            if (start) err_exp = 1;
            @(posedge clk);
            if (wacc) taken++;
            if (hs) begin k++; seen = 1; end
        end
        if (k < n) check_eq("timeout", k, n);
        @(negedge clk);
        start = 1'b0; wv = 1'b0;
        check_eq("err_pulse_end", err, err_exp);
        check_eq("busy_end", busy, 0);
        check_eq("valid_end", ov, 0);
        check_eq("wready_end", wr, 0);
        check_eq("words_used", taken, (n + W - 1) / W);
        if (p_rdy >= 100 && p_wv >= 100) check_eq("bubbles", bubbles, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num = '0; word = '0; wv = 1'b0; rdy = 1'b0;
        @(negedge clk);
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;

        wq.delete(); wq.push_back(8'hA5);
        run_cw(8, 100, 100, -1, 0, -1);

        wq.delete(); wq.push_back(8'hFF); wq.push_back(8'h00); wq.push_back(8'h0F);
        run_cw(20, 100, 100, -1, 0, -1);

        fill_random(16);
        run_cw(16, 60, 60, -1, 0, -1);

        // Zero-length start is refused
        @(negedge clk);
        start = 1'b1; num = '0;
        @(negedge clk);
        start = 1'b0;
        check_eq("zero_err", err, 1);
        check_eq("zero_busy", busy, 0);
        @(negedge clk);
        check_eq("zero_err_clear", err, 0);

        fill_random(13);
        run_cw(13, 80, 80, 4, 0, -1);

        fill_random(11);
        run_cw(11, 100, 100, -1, 1, -1);

        fill_random(24);
        run_cw(24, 100, 100, -1, 0, 5);
        wq.delete(); wq.push_back(8'h3C);
        run_cw(8, 100, 100, -1, 0, -1);

        for (int it = 0; it < 8; it++) begin
            int n;
            n = $urandom_range(60, 1);
            fill_random(n);
            run_cw(n, $urandom_range(100, 40), $urandom_range(100, 40),
                   $urandom_range(n + 5), 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
